// File: rtl/clock_div_pkg.sv
// Shared types and constants for the programmable clock divider.
//   DEF_CNT_WIDTH    : default width of half-period register and counter
//   DEF_NUM_CHANNELS : default channel count
//   half_period_t    : half-period value at default width
//   chan_idx_t       : channel index at default channel count
//   idx_width()      : channel index width, never narrower than 1 bit
package clock_div_pkg;

    localparam int DEF_CNT_WIDTH    = 24;
    localparam int DEF_NUM_CHANNELS = 4;

    typedef logic [DEF_CNT_WIDTH-1:0] half_period_t;
    typedef logic [$clog2(DEF_NUM_CHANNELS)-1:0] chan_idx_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/divider_channel.sv
// One divider channel: counter, half-period register, pending-write register
// and registered square-wave / tick outputs.
//   clk            : divider clock
//   reset          : synchronous, active-low
//   enable         : run enable for this channel
//   sync_restart   : force phase 0 (shared across channels)
//   wr_en          : accepted config write targeting this channel
//   wr_half_period : value of that write
//   pending        : a written H is waiting for a period boundary
//   divided_out    : square wave, toggles every H cycles
//   tick           : one-cycle strobe coincident with each toggle
module divider_channel
    import clock_div_pkg::*;
#(
    parameter int CNT_WIDTH           = DEF_CNT_WIDTH,
    parameter int DEFAULT_HALF_PERIOD = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 sync_restart,
    input  logic                 wr_en,
    input  logic [CNT_WIDTH-1:0] wr_half_period,
    output logic                 pending,
    output logic                 divided_out,
    output logic                 tick
);

    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] half;
    logic [CNT_WIDTH-1:0] next_half;
    logic                 stopped;
    logic                 boundary;
    logic                 load;

    assign stopped  = (half == '0);
    assign boundary = (count == half - CNT_WIDTH'(1));

    // A pending H is only ever loaded when count is (or becomes) 0, so a
    // shorter H can never leave count beyond the new H-1.
    assign load = pending & (sync_restart | stopped | (enable & boundary));

    always_ff @(posedge clk) begin
        if (!reset) begin
            count       <= '0;
            half        <= CNT_WIDTH'(DEFAULT_HALF_PERIOD);
            next_half   <= '0;
            pending     <= 1'b0;
            divided_out <= 1'b0;
            tick        <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (sync_restart) begin
                count       <= '0;
                divided_out <= 1'b0;
            end else if (stopped) begin
                count <= '0;
            end else if (enable) begin
                if (boundary) begin
                    count       <= '0;
                    divided_out <= ~divided_out;
                    tick        <= 1'b1;
                end else begin
                    count <= count + CNT_WIDTH'(1);
                end
            end

            if (load) half <= next_half;

            // wr_en is only asserted while pending is clear, so it never
            // collides with a load; a write landing on a boundary waits for
            // the following boundary.
            if (wr_en) begin
                pending   <= 1'b1;
                next_half <= wr_half_period;
            end else if (load) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/programmable_clock_divider.sv
// Multi-channel runtime-programmable clock divider.
//   internal_oscillator : clock, all logic on rising edge
//   reset               : synchronous, active-low
//   enable              : per-channel run enable
//   sync_restart        : realign all channels to phase 0
//   cfg_valid           : config write request
//   cfg_channel         : target channel
//   cfg_half_period     : new H (0 stops the channel)
//   cfg_ready           : write accepted when cfg_valid & cfg_ready
//   divided_out         : per-channel square waves (registered)
//   tick                : per-channel toggle strobes (registered)
module programmable_clock_divider
    import clock_div_pkg::*;
#(
    parameter int NUM_CHANNELS        = DEF_NUM_CHANNELS,
    parameter int CNT_WIDTH           = DEF_CNT_WIDTH,
    parameter int DEFAULT_HALF_PERIOD = 2
) (
    input  logic                                  internal_oscillator,
    input  logic                                  reset,
    input  logic [NUM_CHANNELS-1:0]               enable,
    input  logic                                  sync_restart,
    input  logic                                  cfg_valid,
    input  logic [idx_width(NUM_CHANNELS)-1:0]    cfg_channel,
    input  logic [CNT_WIDTH-1:0]                  cfg_half_period,
    output logic                                  cfg_ready,
    output logic [NUM_CHANNELS-1:0]               divided_out,
    output logic [NUM_CHANNELS-1:0]               tick
);

    localparam int IDX_W = idx_width(NUM_CHANNELS);

    logic [NUM_CHANNELS-1:0] pending;
    logic [NUM_CHANNELS-1:0] wr_en;
    logic [2**IDX_W-1:0]     pending_pad;

    // Unused index codes read as never-pending, so writes to them are
    // accepted and simply dropped.
    always_comb begin
        pending_pad                   = '0;
        pending_pad[NUM_CHANNELS-1:0] = pending;
        cfg_ready                     = ~pending_pad[cfg_channel];
    end

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
        assign wr_en[i] = cfg_valid & cfg_ready & (cfg_channel == IDX_W'(i));

        divider_channel #(
            .CNT_WIDTH           (CNT_WIDTH),
            .DEFAULT_HALF_PERIOD (DEFAULT_HALF_PERIOD)
        ) u_chan (
            .clk            (internal_oscillator),
            .reset          (reset),
            .enable         (enable[i]),
            .sync_restart   (sync_restart),
            .wr_en          (wr_en[i]),
            .wr_half_period (cfg_half_period),
            .pending        (pending[i]),
            .divided_out    (divided_out[i]),
            .tick           (tick[i])
        );
    end

endmodule

// File: tb/tb_programmable_clock_divider.sv
// Scoreboard bench: the driver advances a countdown-based reference model per
// cycle and queues expected outputs; the monitor pops and compares them.
module tb_programmable_clock_divider;
    import clock_div_pkg::*;

    localparam int N     = 3;   // leaves index code 3 unused
    localparam int DEF_H = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   enable;
    logic           sync_restart;
    logic           cfg_valid;
    logic [1:0]     cfg_channel;
    half_period_t   cfg_half_period;
    logic           cfg_ready;
    logic [N-1:0]   divided_out;
    logic [N-1:0]   tick;

    always #5 clk = ~clk;

    programmable_clock_divider #(
        .NUM_CHANNELS        (N),
        .CNT_WIDTH           (DEF_CNT_WIDTH),
        .DEFAULT_HALF_PERIOD (DEF_H)
    ) dut (
        .internal_oscillator (clk),
        .reset               (reset),
        .enable              (enable),
        .sync_restart        (sync_restart),
        .cfg_valid           (cfg_valid),
        .cfg_channel         (cfg_channel),
        .cfg_half_period     (cfg_half_period),
        .cfg_ready           (cfg_ready),
        .divided_out         (divided_out),
        .tick                (tick)
    );

    typedef struct packed {
        logic [N-1:0] div;
        logic [N-1:0] tck;
        logic         rdy;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;
    int   cycle  = 0;

    // Reference model: cycles left until the next toggle, level and H.
    int unsigned m_h[N];
    int unsigned m_left[N];
    int unsigned m_pend_h[N];
    bit          m_pend[N];
    bit          m_lvl[N];
    bit          m_tick[N];

    function automatic bit exp_ready(input logic [1:0] ch);
        if (int'(ch) >= N) return 1'b1;
        return !m_pend[ch];
    endfunction

    task automatic model_step(input bit rst, input logic [N-1:0] en, input bit sr,
                              input bit v, input logic [1:0] ch, input half_period_t hp);
        bit acc[N];
        for (int c = 0; c < N; c++) acc[c] = v && (int'(ch) == c) && !m_pend[c];
        for (int c = 0; c < N; c++) begin
            if (!rst) begin
                m_h[c] = DEF_H; m_left[c] = DEF_H; m_pend[c] = 0;
                m_lvl[c] = 0; m_tick[c] = 0;
                continue;
            end
            m_tick[c] = 0;
            if (sr) begin
                if (m_pend[c]) begin m_h[c] = m_pend_h[c]; m_pend[c] = 0; end
                m_left[c] = m_h[c];
                m_lvl[c]  = 0;
            end else if (m_h[c] == 0) begin
                if (m_pend[c]) begin m_h[c] = m_pend_h[c]; m_pend[c] = 0; end
                m_left[c] = m_h[c];
            end else if (en[c]) begin
                m_left[c]--;
                if (m_left[c] == 0) begin
                    m_lvl[c]  = ~m_lvl[c];
                    m_tick[c] = 1;
                    if (m_pend[c]) begin m_h[c] = m_pend_h[c]; m_pend[c] = 0; end
                    m_left[c] = m_h[c];
                end
            end
            if (acc[c]) begin m_pend[c] = 1; m_pend_h[c] = hp; end
        end
    endtask

    task automatic cyc(input bit rst, input logic [N-1:0] en, input bit sr,
                       input bit v, input logic [1:0] ch, input half_period_t hp);
        exp_t e;
        @(negedge clk);
        reset = rst; enable = en; sync_restart = sr;
        cfg_valid = v; cfg_channel = ch; cfg_half_period = hp;
        model_step(rst, en, sr, v, ch, hp);
        for (int c = 0; c < N; c++) begin
            e.div[c] = m_lvl[c];
            e.tck[c] = m_tick[c];
        end
        e.rdy = exp_ready(ch);
        q.push_back(e);
    endtask

    task automatic idle(input int n, input logic [N-1:0] en);
        for (int k = 0; k < n; k++) cyc(1'b1, en, 1'b0, 1'b0, 2'd0, '0);
    endtask

    task automatic wr(input logic [N-1:0] en, input logic [1:0] ch, input int unsigned hp);
        cyc(1'b1, en, 1'b0, 1'b1, ch, half_period_t'(hp));
    endtask

    // Monitor: outputs are presented every cycle after the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                cycle++;
                checks++;
                if (divided_out === e.div && tick === e.tck) passed++;
                else $display("FAIL outputs cycle %0d: div=%b tick=%b, expected div=%b tick=%b",
                              cycle, divided_out, tick, e.div, e.tck);
                checks++;
                if (cfg_ready === e.rdy) passed++;
                else $display("FAIL cfg_ready cycle %0d: got %b, expected %b",
                              cycle, cfg_ready, e.rdy);
            end
        end
    end

    initial begin
        reset = 0; enable = '1; sync_restart = 0;
        cfg_valid = 0; cfg_channel = 0; cfg_half_period = '0;

        // 1: reset, then default H=2 on all channels
        cyc(1'b0, '1, 1'b0, 1'b0, 2'd0, '0);
        cyc(1'b0, '1, 1'b0, 1'b0, 2'd0, '0);
        idle(11, '1);
        // 2: ch1 H=5 mid-period
        wr('1, 2'd1, 5);
        idle(16, '1);
        // 3: stop ch2, then restart with H=3
        wr('1, 2'd2, 0);
        idle(8, '1);
        wr('1, 2'd2, 3);
        idle(12, '1);
        // 4: ch0 disabled for 7 cycles
        idle(7, 3'b110);
        idle(8, '1);
        // 5: H = 2,3,4 then sync_restart
        wr('1, 2'd0, 2);
        wr('1, 2'd1, 3);
        wr('1, 2'd2, 4);
        idle(12, '1);
        cyc(1'b1, '1, 1'b1, 1'b0, 2'd0, '0);
        idle(10, '1);
        // 6: pending write wiped by a 1-cycle reset
        wr('1, 2'd2, 6);
        cyc(1'b0, '1, 1'b0, 1'b0, 2'd2, '0);
        idle(8, '1);
        // write to the unused index is accepted and dropped
        wr('1, 2'd3, 1);
        idle(6, '1);
        // H=1 on ch0
        wr('1, 2'd0, 1);
        idle(6, '1);

        // randomized traffic
        for (int k = 0; k < 700; k++) begin
            logic [N-1:0] en;
            half_period_t hp;
            for (int c = 0; c < N; c++) en[c] = ($urandom_range(0, 99) < 85);
            hp = ($urandom_range(0, 19) == 0) ? half_period_t'($urandom_range(7, 20))
                                              : half_period_t'($urandom_range(0, 6));
            cyc($urandom_range(0, 149) != 0, en, $urandom_range(0, 39) == 0,
                $urandom_range(0, 9) < 4, 2'($urandom_range(0, 3)), hp);
        end

        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
        @(posedge clk);
        #2;
        checks++;
        if (q.size() == 0) passed++;
        else $display("FAIL drain: %0d entries left, expected 0", q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
